div_job_sequencer: RTL and testbench

// - Upstream/downstream wrapper for the 8-bit non-restoring divider: accepts dividend/divisor jobs on a

---
 rtl/div_job_sequencer_pkg.sv | 33 +++
 rtl/div_job_sequencer_if.sv | 40 ++++
 rtl/div_job_sequencer_fifo.sv | 62 ++++++
 rtl/div_job_sequencer.sv | 146 ++++++++++++++
 tb/tb_div_job_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_job_sequencer_pkg.sv
// ============================================================================
// Module : div_seq_pkg
// Brief  : Shared types for the divider job sequencer (states, job, result).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REARM = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
    } job_t;

    typedef struct packed {
        logic [DATA_W-1:0] quotient;
        logic [DATA_W-1:0] remainder;
        logic              err;
    } result_t;

endpackage

`default_nettype wire

// File: rtl/div_job_sequencer_if.sv
// ============================================================================
// Module : div_job_sequencer_if
// Brief  : Job input stream, divider handshake and result output stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_job_sequencer_if;
    import div_seq_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_dividend;
    logic [DATA_W-1:0]   in_divisor;
    logic                div_rst_n;
    logic                div_req;
    logic [2*DATA_W-1:0] div_values;
    logic                div_ack;
    logic [2*DATA_W-1:0] div_result;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_quotient;
    logic [DATA_W-1:0]   out_remainder;
    logic                out_err;

    modport master (
        input  in_valid, in_dividend, in_divisor, div_ack, div_result, out_ready,
        output in_ready, div_rst_n, div_req, div_values,
               out_valid, out_quotient, out_remainder, out_err
    );

    modport slave (
        output in_valid, in_dividend, in_divisor, div_ack, div_result, out_ready,
        input  in_ready, div_rst_n, div_req, div_values,
               out_valid, out_quotient, out_remainder, out_err
    );

endinterface

`default_nettype wire

// File: rtl/div_job_sequencer_fifo.sv
// ============================================================================
// Module : div_job_fifo
// Brief  : Synchronous job FIFO, DEPTH x WIDTH, first-word fall-through read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_data  = r_mem[r_rd];
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_job_sequencer.sv
// ============================================================================
// Module : div_job_sequencer
// Brief  : Buffers divide jobs, re-arms and drives the divider per job,
//          times out hung transactions. Option: DIV_ZERO_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_job_sequencer
    import div_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input  wire logic             clk,
    input  wire logic             reset,
    div_job_sequencer_if.master   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    state_t             w_next;
    job_t               r_job;
    job_t               w_head;
    result_t            r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_timeout;
    logic               w_dz;
    logic               w_rst_n;
    logic               w_req;
    logic [2*DATA_W-1:0] w_values;

    assign bus.in_ready = !reset && !w_full;
    assign w_push       = bus.in_valid && bus.in_ready;

    div_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({bus.in_dividend, bus.in_divisor}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef DIV_ZERO_CHECK_EN
    assign w_dz = (w_head.divisor == '0);
`else
    assign w_dz = 1'b0;
`endif

    assign w_timeout = (r_state == WAIT) && !bus.div_ack && (r_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_rst_n  = 1'b1;
        w_req    = 1'b0;
        w_values = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = w_dz ? OUT : REARM;
                end
            end
            REARM: begin
                w_rst_n  = 1'b0;
                w_values = r_job;
                w_next   = REQ;
            end
            REQ: begin
                w_req    = 1'b1;
                w_values = r_job;
                w_next   = WAIT;
            end
            WAIT: begin
                // Divider samples operands a cycle after req, so keep them driven.
                w_values = r_job;
                if (bus.div_ack) begin
                    w_next = OUT;
                end else if (w_timeout) begin
                    w_rst_n = 1'b0;
                    w_next  = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_job <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_job <= w_head;
                        if (w_dz) r_res <= '{quotient: 8'hFF, remainder: w_head.dividend, err: 1'b1};
                    end
                end
                REQ: r_cnt <= '0;
                WAIT: begin
                    if (bus.div_ack)
                        r_res <= '{quotient: bus.div_result[7:0],
                                   remainder: bus.div_result[15:8], err: 1'b0};
                    else if (w_timeout)
                        r_res <= '{quotient: '0, remainder: '0, err: 1'b1};
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.div_rst_n     = w_rst_n && !reset;
    assign bus.div_req       = w_req;
    assign bus.div_values    = w_values;
    assign bus.out_valid     = (r_state == OUT);
    assign bus.out_quotient  = r_res.quotient;
    assign bus.out_remainder = r_res.remainder;
    assign bus.out_err       = r_res.err;

endmodule

`default_nettype wire

// File: tb/tb_div_job_sequencer.sv
// ============================================================================
// Module : tb_div_job_sequencer
// Brief  : Scoreboard bench for div_job_sequencer with a behavioural divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_job_sequencer;
    import div_seq_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 63;
    localparam int LAT         = 8;
`ifdef DIV_ZERO_CHECK_EN
    localparam logic DZ_ERR = 1'b1;
    localparam int   DZ_REQ = 0;
`else
    localparam logic DZ_ERR = 1'b0;
    localparam int   DZ_REQ = 1;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_job_sequencer_if bus ();

    div_job_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t m_e;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_req   = 0;
    int   n_rearm = 0;

    // Behavioural divider: samples operands the cycle after req, acks LAT cycles later.
    logic        m_hang = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_ack  = 1'b0;
    logic [15:0] m_op   = '0;
    logic [15:0] m_res  = '0;
    int          m_cnt  = 0;

    function automatic logic [15:0] mdiv(input logic [15:0] v);
        logic [7:0] a;
        logic [7:0] b;
        a = v[15:8];
        b = v[7:0];
        if (b == 8'd0) return {a, 8'hFF};
        return {8'(a % b), 8'(a / b)};
    endfunction

    always @(posedge clk) begin
        m_ack <= 1'b0;
        if (!bus.div_rst_n) begin
            m_pend <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            if (bus.div_req) m_pend <= 1'b1;
            if (m_pend) begin
                m_pend <= 1'b0;
                m_busy <= 1'b1;
                m_cnt  <= LAT;
                m_op   <= bus.div_values;
            end else if (m_busy && !m_hang) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_ack  <= 1'b1;
                    m_res  <= mdiv(m_op);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign bus.div_ack    = m_ack;
    assign bus.div_result = m_res;

    // Monitor: pops the scoreboard on every output handshake, counts divider pulses.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got q=%0d r=%0d err=%0d, none expected",
                         bus.out_quotient, bus.out_remainder, bus.out_err);
            end else begin
                m_e = exp_q.pop_front();
                if (bus.out_quotient !== m_e.q || bus.out_remainder !== m_e.r || bus.out_err !== m_e.err) begin
                    n_err++;
                    $display("FAIL result: got q=%0d r=%0d err=%0d, expected q=%0d r=%0d err=%0d",
                             bus.out_quotient, bus.out_remainder, bus.out_err, m_e.q, m_e.r, m_e.err);
                end
            end
        end
        if (!reset && !bus.div_rst_n) n_rearm++;
        if (!reset && bus.div_req)    n_req++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r, input logic e);
        int k;
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.in_ready && k < 500);
        if (!bus.in_ready) begin
            check("send_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back('{q: q, r: r, err: e});
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s_req;
        int   s_rearm;
        int   k;
        logic ok;
        exp_t snap;

        bus.in_valid    = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  0);
        check("rst_div_rst_n", {31'd0, bus.div_rst_n}, 0);
        check("rst_div_req",   {31'd0, bus.div_req},   0);
        check("rst_div_values", {16'd0, bus.div_values}, 0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_data",  {15'd0, bus.out_quotient, bus.out_remainder, bus.out_err}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready",  {31'd0, bus.in_ready},  1);
        check("post_rst_div_rst_n", {31'd0, bus.div_rst_n}, 1);

        // Single job
        s_req = n_req; s_rearm = n_rearm;
        send(200, 7, 28, 4, 0);
        drain(200);
        check("single_req_count",   n_req - s_req, 1);
        check("single_rearm_count", n_rearm - s_rearm, 1);

        // Four back-to-back jobs
        s_req = n_req; s_rearm = n_rearm;
        send(255, 1, 255, 0, 0);
        send(5, 9, 0, 5, 0);
        send(100, 10, 10, 0, 0);
        send(17, 3, 5, 2, 0);
        drain(400);
        check("b2b_req_count",   n_req - s_req, 4);
        check("b2b_rearm_count", n_rearm - s_rearm, 4);

        // Fill the FIFO while the divider is stalled
        m_hang = 1'b1;
        s_req  = n_req;
        send(20, 3, 6, 2, 0);
        send(99, 9, 11, 0, 0);
        send(7, 2, 3, 1, 0);
        send(240, 16, 15, 0, 0);
        send(13, 5, 2, 3, 0);
        @(negedge clk);
        check("full_in_ready", {31'd0, bus.in_ready}, 0);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd60;
        bus.in_divisor  = 8'd7;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b0;
        end
        check("full_holds_off", {31'd0, ok}, 1);
        m_hang = 1'b0;
        send(60, 7, 8, 4, 0);
        drain(600);
        check("full_req_count", n_req - s_req, 6);

        // Output backpressure
        bus.out_ready = 1'b0;
        send(77, 8, 9, 5, 0);
        send(30, 4, 7, 2, 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 200);
        check("hold_out_valid", {31'd0, bus.out_valid}, 1);
        snap  = '{q: bus.out_quotient, r: bus.out_remainder, err: bus.out_err};
        s_req = n_req;
        ok    = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_quotient !== snap.q ||
                bus.out_remainder !== snap.r || bus.out_err !== snap.err) ok = 1'b0;
        end
        check("hold_stable", {31'd0, ok}, 1);
        check("hold_no_new_req", n_req - s_req, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain(300);

        // Divider never acks -> timeout, then a normal job
        m_hang = 1'b1;
        s_req = n_req; s_rearm = n_rearm;
        send(123, 4, 0, 0, 1);
        drain(400);
        check("timeout_req_count",   n_req - s_req, 1);
        check("timeout_rearm_count", n_rearm - s_rearm, 2);
        m_hang = 1'b0;
        send(50, 5, 10, 0, 0);
        drain(200);

        // Divide by zero
        s_req = n_req;
        send(9, 0, 8'hFF, 9, DZ_ERR);
        drain(200);
        check("dz_req_count", n_req - s_req, DZ_REQ);

        // Reset while waiting on the divider
        m_hang = 1'b1;
        s_req  = n_req;
        send(88, 8, 11, 0, 0);
        k = 0;
        while (n_req == s_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrst_in_ready",  {31'd0, bus.in_ready},  0);
        check("midrst_div_rst_n", {31'd0, bus.div_rst_n}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_hang = 1'b0;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b0;
        end
        check("midrst_no_output", {31'd0, ok}, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
